// File: rtl/axis_fifo.sv
// -----------------------------------------------------------------------------
// axis_fifo
//
// Single-clock AXI-Stream FIFO with show-ahead output. Each entry holds
// {tlast, tdata}. The head entry is presented on m_tdata/m_tlast whenever
// m_tvalid is high, so a word written into an empty FIFO is visible one cycle
// after the write edge.
//
// Handshake (both sides): a transfer happens on a rising clock edge where
// valid and ready are both 1 and rst is 1. A source never depends on ready to
// raise valid; ready here depends only on the registered FSM state, never on
// the same-cycle valid.
//
// Ports
//   clk        in   1        single clock, rising edge
//   rst        in   1        synchronous reset, active low (0 = reset)
//   s_tdata    in   DW       slave data
//   s_tvalid   in   1        slave valid
//   s_tlast    in   1        slave end-of-packet, stored with the word
//   s_tready   out  1        FIFO can accept (not FULL)
//   m_tdata    out  DW       head entry data (0 when empty)
//   m_tvalid   out  1        FIFO non-empty
//   m_tlast    out  1        head entry tlast (0 when empty)
//   m_tready   in   1        downstream ready
//   fifo_count out  AW+1     registered occupancy, only with AXIS_FIFO_COUNT_EN
//
// Configuration
//   AXIS_FIFO_COUNT_EN  when defined, adds the fifo_count output port.
//
// The control FSM state is held in the signal `state` (EMPTY/PARTIAL/FULL)
// so checkers can bind to it directly.
// -----------------------------------------------------------------------------
module axis_fifo #(
   parameter int DW = 8,
   parameter int DD = 2048
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DW-1:0]         s_tdata,
   input  logic                  s_tvalid,
   input  logic                  s_tlast,
   output logic                  s_tready,
   output logic [DW-1:0]         m_tdata,
   output logic                  m_tvalid,
   output logic                  m_tlast,
   input  logic                  m_tready
`ifdef AXIS_FIFO_COUNT_EN
   ,
   output logic [$clog2(DD):0]   fifo_count
`endif
);

   localparam int AW = $clog2(DD);
   localparam int CW = AW + 1;

   localparam logic [CW-1:0] CNT_ONE      = CW'(1);
   localparam logic [CW-1:0] CNT_FULL     = CW'(DD);
   localparam logic [CW-1:0] CNT_NEARFULL = CW'(DD - 1);

   typedef enum logic [1:0] {
      EMPTY   = 2'd0,
      PARTIAL = 2'd1,
      FULL    = 2'd2
   } state_t;

   // Storage and registered bookkeeping
   logic [DW:0]   mem [DD];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;
   state_t        state;
   state_t        state_nxt;

   logic          wr_en;
   logic          rd_en;
   logic [DW:0]   head;

   // Ready/valid come straight from the registered state.
   assign s_tready = (state != FULL);
   assign m_tvalid = (state != EMPTY);

   // Transfers are suppressed while reset is asserted. A FULL FIFO refuses a
   // write even when a pop happens in the same cycle, because s_tready is
   // derived from the state and not from m_tready.
   assign wr_en = rst & s_tvalid & s_tready;
   assign rd_en = rst & m_tvalid & m_tready;

   // Show-ahead read of the head entry; outputs are forced to 0 while empty
   // so that stale storage never reaches the bus after reset or drain.
   assign head    = mem[rd_ptr];
   assign m_tdata = m_tvalid ? head[DW-1:0] : '0;
   assign m_tlast = m_tvalid ? head[DW]     : 1'b0;

`ifdef AXIS_FIFO_COUNT_EN
   assign fifo_count = count;
`endif

   // ---------------------------------------------------------------------------
   // Storage array: no reset, contents are only meaningful between pointers.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr] <= {s_tlast, s_tdata};
      end
   end

   // ---------------------------------------------------------------------------
   // Pointers and occupancy. DD is a power of two, so pointer wrap from DD-1
   // to 0 is the natural overflow of an AW-bit counter.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (rd_en) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({wr_en, rd_en})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Control FSM: state register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= EMPTY;
      end else begin
         state <= state_nxt;
      end
   end

   // ---------------------------------------------------------------------------
   // Control FSM: next state. A simultaneous write and read never changes the
   // occupancy, so it always holds the current state.
   // ---------------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      case (state)
         EMPTY: begin
            if (wr_en) begin
               state_nxt = PARTIAL;
            end
         end
         PARTIAL: begin
            if (wr_en && !rd_en && (count == CNT_NEARFULL)) begin
               state_nxt = FULL;
            end else if (rd_en && !wr_en && (count == CNT_ONE)) begin
               state_nxt = EMPTY;
            end
         end
         FULL: begin
            if (rd_en) begin
               state_nxt = PARTIAL;
            end
         end
         default: begin
            state_nxt = EMPTY;
         end
      endcase
   end

`ifndef SYNTHESIS
   // State and occupancy must always agree.
   always_ff @(posedge clk) begin
      if (rst) begin
         assert (count <= CNT_FULL)
            else $error("axis_fifo: occupancy above depth");
         assert ((state == EMPTY) == (count == '0))
            else $error("axis_fifo: EMPTY state disagrees with occupancy");
         assert ((state == FULL) == (count == CNT_FULL))
            else $error("axis_fifo: FULL state disagrees with occupancy");
      end
   end
`endif

endmodule

// File: tb/tb_axis_fifo.sv
// -----------------------------------------------------------------------------
// tb_axis_fifo
//
// Bench for axis_fifo (DW=8, DD=2048). A queue holds the words the FIFO should
// contain; every cycle the bench decides from that queue alone whether a write
// and/or pop happens, then compares the DUT's outputs with the queue's
// contents.
// -----------------------------------------------------------------------------
module tb_axis_fifo;

   localparam int DW = 8;
   localparam int DD = 2048;
   localparam int CW = $clog2(DD) + 1;

   // ---------------------------------------------------------------------------
   // Clock / reset
   // ---------------------------------------------------------------------------
   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [DW-1:0] s_tdata = '0;
   logic          s_tvalid = 1'b0;
   logic          s_tlast = 1'b0;
   logic          s_tready;
   logic [DW-1:0] m_tdata;
   logic          m_tvalid;
   logic          m_tlast;
   logic          m_tready = 1'b0;
`ifdef AXIS_FIFO_COUNT_EN
   logic [CW-1:0] fifo_count;
`endif

   always #5 clk = ~clk;

   axis_fifo #(.DW(DW), .DD(DD)) dut (
      .clk        (clk),
      .rst        (rst),
      .s_tdata    (s_tdata),
      .s_tvalid   (s_tvalid),
      .s_tlast    (s_tlast),
      .s_tready   (s_tready),
      .m_tdata    (m_tdata),
      .m_tvalid   (m_tvalid),
      .m_tlast    (m_tlast),
      .m_tready   (m_tready)
`ifdef AXIS_FIFO_COUNT_EN
      ,
      .fifo_count (fifo_count)
`endif
   );

   // ---------------------------------------------------------------------------
   // Scoreboard: expected FIFO contents, {tlast, tdata}, head at index 0
   // ---------------------------------------------------------------------------
   logic [DW:0] exp_q[$];
   int          n_tests = 0;
   int          n_fail  = 0;
   int          max_occ = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Compare all DUT outputs with what the expected queue implies.
   task automatic check_outputs();
      logic [DW:0] hd;
      chk("s_tready", 32'(s_tready), 32'(exp_q.size() < DD));
      chk("m_tvalid", 32'(m_tvalid), 32'(exp_q.size() > 0));
      if (exp_q.size() > 0) begin
         hd = exp_q[0];
         chk("m_tdata", 32'(m_tdata), 32'(hd[DW-1:0]));
         chk("m_tlast", 32'(m_tlast), 32'(hd[DW]));
      end
`ifdef AXIS_FIFO_COUNT_EN
      chk("fifo_count", 32'(fifo_count), 32'(exp_q.size()));
`endif
   endtask

   // ---------------------------------------------------------------------------
   // Driver: apply one cycle of inputs, advance the expected queue by the
   // AXI-Stream rules, then check outputs #1 after the edge.
   // ---------------------------------------------------------------------------
   task automatic cycle(input logic r, input logic sv, input logic [DW-1:0] sd,
                        input logic sl, input logic mr);
      logic acc;
      logic pop;
      rst      = r;
      s_tvalid = sv;
      s_tdata  = sd;
      s_tlast  = sl;
      m_tready = mr;
      acc = r && sv && (exp_q.size() < DD);
      pop = r && mr && (exp_q.size() > 0);
      @(posedge clk);
      #1;
      if (!r) begin
         exp_q.delete();
      end else begin
         if (pop) void'(exp_q.pop_front());
         if (acc) exp_q.push_back({sl, sd});
      end
      if (exp_q.size() > max_occ) max_occ = exp_q.size();
      check_outputs();
   endtask

   // ---------------------------------------------------------------------------
   // Directed table: inputs for one cycle and the outputs expected after it
   // ---------------------------------------------------------------------------
   typedef struct {
      logic          r;
      logic          sv;
      logic [DW-1:0] sd;
      logic          sl;
      logic          mr;
      logic          e_srdy;
      logic          e_mval;
      logic [DW-1:0] e_mdata;
      logic          e_mlast;
   } vec_t;

   vec_t vecs[11];

   initial begin
      // Words are written into an empty FIFO with the reset released.
      vecs[0]  = '{1'b1, 1'b1, 8'hA5, 1'b1, 1'b0,  1'b1, 1'b1, 8'hA5, 1'b1}; // single word visible
      vecs[1]  = '{1'b1, 1'b0, 8'hFF, 1'b0, 1'b0,  1'b1, 1'b1, 8'hA5, 1'b1}; // held, idle data ignored
      vecs[2]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0,  1'b1, 1'b1, 8'hA5, 1'b1}; // still held
      vecs[3]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1,  1'b1, 1'b0, 8'h00, 1'b0}; // popped -> empty
      vecs[4]  = '{1'b1, 1'b1, 8'h3C, 1'b0, 1'b1,  1'b1, 1'b1, 8'h3C, 1'b0}; // no pop from empty
      vecs[5]  = '{1'b1, 1'b1, 8'h5A, 1'b1, 1'b1,  1'b1, 1'b1, 8'h5A, 1'b1}; // write+read at count 1
      vecs[6]  = '{1'b1, 1'b1, 8'h77, 1'b0, 1'b0,  1'b1, 1'b1, 8'h5A, 1'b1}; // second word behind head
      vecs[7]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1,  1'b1, 1'b1, 8'h77, 1'b0}; // pop reveals 0x77
      vecs[8]  = '{1'b0, 1'b1, 8'h11, 1'b1, 1'b1,  1'b1, 1'b0, 8'h00, 1'b0}; // reset discards
      vecs[9]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1,  1'b1, 1'b0, 8'h00, 1'b0}; // nothing reappears
      vecs[10] = '{1'b0, 1'b1, 8'hC3, 1'b1, 1'b0,  1'b1, 1'b0, 8'h00, 1'b0}; // no write during reset
   end

   // ---------------------------------------------------------------------------
   // Test sequence
   // ---------------------------------------------------------------------------
   initial begin
      logic [DW-1:0] d;
      logic [DW-1:0] old_words[10];

      // Reset: low for three cycles, then release.
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, '0, 1'b0, 1'b0);
      cycle(1'b1, 1'b0, '0, 1'b0, 1'b0);
      chk("reset_s_tready", 32'(s_tready), 32'd1);
      chk("reset_m_tvalid", 32'(m_tvalid), 32'd0);
      chk("reset_m_tdata",  32'(m_tdata),  32'd0);
      chk("reset_m_tlast",  32'(m_tlast),  32'd0);
`ifdef AXIS_FIFO_COUNT_EN
      chk("reset_fifo_count", 32'(fifo_count), 32'd0);
`endif

      // Directed vectors
      for (int i = 0; i < 11; i++) begin
         cycle(vecs[i].r, vecs[i].sv, vecs[i].sd, vecs[i].sl, vecs[i].mr);
         chk($sformatf("vec%0d_s_tready", i), 32'(s_tready), 32'(vecs[i].e_srdy));
         chk($sformatf("vec%0d_m_tvalid", i), 32'(m_tvalid), 32'(vecs[i].e_mval));
         chk($sformatf("vec%0d_m_tdata", i),  32'(m_tdata),  32'(vecs[i].e_mdata));
         chk($sformatf("vec%0d_m_tlast", i),  32'(m_tlast),  32'(vecs[i].e_mlast));
      end
      cycle(1'b1, 1'b0, '0, 1'b0, 1'b0);

      // Streaming: 4000 random bytes with downstream always ready.
      max_occ = 0;
      for (int i = 0; i < 4000; i++) begin
         cycle(1'b1, 1'b1, DW'($urandom_range(0, 255)), 1'b0, 1'b1);
         chk("stream_s_tready", 32'(s_tready), 32'd1);
      end
      chk("stream_max_occupancy", 32'(max_occ), 32'd1);
      for (int i = 0; i < 4 && exp_q.size() > 0; i++) cycle(1'b1, 1'b0, '0, 1'b0, 1'b1);
      chk("stream_drained", 32'(m_tvalid), 32'd0);

      // Random traffic with random back-pressure on both sides.
      for (int i = 0; i < 3000; i++) begin
         cycle(1'b1, 1'($urandom_range(0, 3) != 0), DW'($urandom), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 2) == 0));
      end
      for (int i = 0; i < DD + 4 && exp_q.size() > 0; i++) cycle(1'b1, 1'b0, '0, 1'b0, 1'b1);
      chk("random_drained", 32'(m_tvalid), 32'd0);

      // Fill: 2048 writes with downstream stalled.
      for (int i = 0; i < DD; i++) begin
         cycle(1'b1, 1'b1, DW'($urandom), 1'($urandom_range(0, 1)), 1'b0);
      end
      chk("fill_s_tready_full", 32'(s_tready), 32'd0);
      for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, DW'(8'hE0 + i), 1'b1, 1'b0);
      chk("fill_rejects_extra", 32'(exp_q.size()), 32'(DD));
      cycle(1'b1, 1'b0, '0, 1'b0, 1'b1);
      chk("fill_pop_s_tready", 32'(s_tready), 32'd1);
      cycle(1'b1, 1'b1, 8'h42, 1'b0, 1'b0);
      chk("refill_s_tready", 32'(s_tready), 32'd0);

      // FULL with both sides active: pop only, occupancy drops to DD-1.
      cycle(1'b1, 1'b1, 8'hBD, 1'b1, 1'b1);
      chk("full_simul_occupancy", 32'(exp_q.size()), 32'(DD - 1));
      chk("full_simul_s_tready", 32'(s_tready), 32'd1);
      // Steady write+read through pointer wrap.
      for (int i = 0; i < 3000; i++) begin
         cycle(1'b1, 1'b1, DW'($urandom), 1'($urandom_range(0, 1)), 1'b1);
      end
      chk("simul_occupancy_kept", 32'(exp_q.size()), 32'(DD - 1));

      // Mid-operation reset with 10 words stored.
      cycle(1'b0, 1'b0, '0, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) begin
         d = DW'(8'h80 + i);
         old_words[i] = d;
         cycle(1'b1, 1'b1, d, 1'b1, 1'b0);
      end
      chk("midrst_stored", 32'(m_tdata), 32'(old_words[0]));
      cycle(1'b0, 1'b0, '0, 1'b0, 1'b1);
      chk("midrst_m_tvalid", 32'(m_tvalid), 32'd0);
      chk("midrst_s_tready", 32'(s_tready), 32'd1);
      for (int i = 0; i < 4; i++) begin
         cycle(1'b1, 1'b0, '0, 1'b0, 1'b1);
         chk("midrst_stays_empty", 32'(m_tvalid), 32'd0);
      end
      cycle(1'b1, 1'b1, 8'h5C, 1'b0, 1'b0);
      chk("midrst_new_word", 32'(m_tdata), 32'h5C);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Global time limit so the run always ends.
   initial begin
      #2_000_000;
      n_fail++;
      $display("FAIL timeout: simulation exceeded time limit");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/axis_fifo.md
AXIS_FIFO -- requirements
Module: axis_fifo

Interface
REQ-001 Parameter DW, default 8, tdata width in bits (>=1).
REQ-002 Parameter DD, default 2048, FIFO depth in entries (power of two, >=4).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-low (0 = reset).
REQ-005 s_tdata  input  DW  slave-side data.
REQ-006 s_tvalid  input  1  slave-side valid.
REQ-007 s_tlast  input  1  slave-side end-of-packet marker, stored with each word.
REQ-008 s_tready  output  1  slave-side ready (FIFO can accept).
REQ-009 m_tdata  output  DW  master-side data (head entry).
REQ-010 m_tvalid  output  1  master-side valid (FIFO non-empty).
REQ-011 m_tlast  output  1  master-side tlast of head entry.
REQ-012 m_tready  input  1  master-side ready from downstream.

Function
REQ-013 Storage SHALL be DD entries of {tlast, tdata}; write pointer, read pointer and occupancy count (0..DD, $clog2(DD)+1 bits) SHALL be registered.
REQ-014 Write SHALL occur on a rising edge where s_tvalid=1 and s_tready=1; read (pop) SHALL occur where m_tvalid=1 and m_tready=1.
REQ-015 Pointers SHALL advance by 1 per write/read and wrap from DD-1 to 0.
REQ-016 Control FSM SHALL have states EMPTY (count=0), PARTIAL (0<count<DD), FULL (count=DD).
REQ-017 Transitions: EMPTY->PARTIAL on write; PARTIAL->EMPTY on read-only with count=1; PARTIAL->FULL on write-only with count=DD-1; FULL->PARTIAL on read; otherwise hold.
REQ-018 Simultaneous write and read SHALL leave count and state unchanged and both pointers advanced.
REQ-019 s_tready SHALL be 1 in EMPTY and PARTIAL, 0 in FULL; in FULL a write is not accepted even if a read occurs the same cycle.
REQ-020 m_tvalid SHALL be 1 in PARTIAL and FULL, 0 in EMPTY; a pop is never performed in EMPTY.
REQ-021 Show-ahead behaviour: m_tdata/m_tlast SHALL present the entry at the read pointer whenever m_tvalid=1; a word written into an empty FIFO at edge N SHALL be visible with m_tvalid=1 after edge N (1-cycle latency).
REQ-022 m_tdata/m_tlast SHALL remain stable while m_tvalid=1 and m_tready=0.
REQ-023 Data order SHALL be strict FIFO; tlast SHALL travel unaltered with its word; no packet-level gating.
REQ-024 s_tdata/s_tlast SHALL be ignored when no write occurs.

Reset
REQ-025 On a rising edge with rst=0: pointers and count SHALL clear, FSM SHALL enter EMPTY, so s_tready=1, m_tvalid=0, m_tlast=0, m_tdata=0 from the next cycle.
REQ-026 Reset mid-operation SHALL discard all stored entries; storage array contents need not be cleared.
REQ-027 No write or read SHALL occur on a cycle where rst=0.

Configuration
REQ-028 Macro AXIS_FIFO_COUNT_EN: when defined, an extra output port fifo_count ($clog2(DD)+1 bits) SHALL expose the registered occupancy (0 at reset, DD when FULL); when undefined, the port SHALL not exist and behaviour is otherwise identical.

Verification
REQ-029 Reset: rst=0 for 3 cycles then 1 -> s_tready=1, m_tvalid=0, m_tdata=0 (fifo_count=0 if enabled).
REQ-030 Single word: write 0xA5 tlast=1 into empty FIFO, m_tready=0 -> next cycle m_tvalid=1, m_tdata=0xA5, m_tlast=1, held until m_tready=1, then m_tvalid=0.
REQ-031 Streaming: m_tready=1, s_tvalid=1, 4000 random bytes with tlast=0 -> every byte emerges in order, no loss, count never exceeds 1, s_tready stays 1.
REQ-032 Fill: m_tready=0, write 2048 words -> s_tready=0 after the 2048th write, extra s_tvalid words rejected; then one pop -> s_tready=1 next cycle.
REQ-033 Full simultaneous: FULL with s_tvalid=1, m_tready=1 -> pop only, count becomes 2047; then simultaneous write+read keeps count at 2047 and order intact through pointer wrap.
REQ-034 Mid-operation reset: 10 words stored, rst=0 one cycle -> m_tvalid=0, s_tready=1; stored words never appear on m_tdata.
